life_display_scanner: RTL and testbench
=======================================

# life_display_scanner

Downstream consumer of the Game-of-Life cell array: takes the flattened `state_q` outputs of all N×N cells, holds a tear-free snapshot of the current generation, and time-multiplexes it onto an N×N LED matrix one row at a time. It sits between the cell array and the board pins. It uses the same `ena` generation-step strobe that advances the cells, so a new generation is picked up only at a frame boundary.

## Interface
- `N`, default 8: board dimension (rows = columns = N); N ≥ 2.
- `DWELL`, default 1024: cycles each row is driven; ≥ 1.
- `BLANK`, default 4: dark cycles before each row (anti-ghosting); ≥ 1.
- `clk`  in  1: the single clock.
- `rst`  in  1: reset; synchronous, active-high.
- `ena`  in  1: generation step strobe, same net that enables the cells.
- `cells`  in  N*N: live cell states; cell (r,c) at index r*N+c.
- `rows`  out  N: one-hot row drive, active-high; all-zero when dark.
- `cols`  out  N: column data for the driven row, active-high; bit c = cell (r,c).
- `frame_done`  out  1: one-cycle pulse on the last driven cycle of row N-1.

## Operation
- Cells update on the edge where `ena`=1. The new values are valid in the following cycle. The block registers `ena` into `ena_d` and treats `ena_d`=1 as "`cells` now holds a new generation".
- `pending` flag:
  - Set by `ena_d`.
  - Cleared when a snapshot loads.
  - Set at reset, so the first frame shows the reset pattern.
- Snapshot register (N*N bits) is loaded from `cells` only on the last BLANK cycle of row 0, and only if `pending`=1 or `ena_d`=1 in that same cycle. A simultaneous `ena_d` counts as loaded, and `pending` ends cleared.
- Multiple `ena` pulses within one frame: only the latest generation is displayed. Intermediate generations are dropped silently.
- `cells` changing without `ena` has no effect on the display.
- FSM states:
  - BLANK: `rows`=0, `cols`=0. Phase counter runs 0..BLANK-1, then the FSM goes to DRIVE.
  - DRIVE: `rows`=one-hot(row), `cols`=snapshot[row*N +: N]. Phase counter runs 0..DWELL-1. Then row ← (row+1) mod N and the FSM goes to BLANK.
- `frame_done`=1 exactly when state=DRIVE, row=N-1 and phase=DWELL-1.
- `rows`, `cols` and `frame_done` decode from registered state and snapshot only. There is no combinational path from `cells` or `ena` to any output.
- Width rules:
  - Row counter: $clog2(N) bits, explicit wrap at N-1 (N need not be a power of 2).
  - Phase counter: $clog2(max(DWELL,BLANK)+1) bits.

## Timing
- Reset values (effective the cycle after `rst` is sampled high):
  - state=BLANK, row=0, phase=0.
  - snapshot=0, `pending`=1, `ena_d`=0.
  - `rows`=0, `cols`=0, `frame_done`=0.
- `rst` asserted mid-frame: the display goes dark from the next cycle and the frame restarts at row 0. Any pending generation is replaced by reloading whatever `cells` holds at the first row-0 load point.
- Frame length is exactly N*(BLANK+DWELL) cycles. Row r is driven on cycles r*(BLANK+DWELL)+BLANK … (r+1)*(BLANK+DWELL)-1, counting from the first cycle after reset release.
- Load-to-display latency is 1 cycle: the snapshot loaded on the last BLANK cycle of row 0 appears on `cols` in the next cycle (the first DRIVE cycle of row 0).
- `ena` to display: worst case is just under one frame plus BLANK+1 cycles.

## Structure
- `conway_pkg` holds:
  - the FSM state enum typedef {BLANK, DRIVE};
  - a `cell_index(r,c,N)` constant function, shared with the cell-array generator.
- One sub-module is natural: `row_decoder`, which is parameterised on N and maps a binary row index plus an enable to a one-hot `rows` vector.
- Snapshot, counters and FSM stay in the top module.

## Test plan
All scenarios use N=4, DWELL=3, BLANK=2, so one frame is 20 cycles. Cycles are counted from the first cycle after reset release.
- **Reset:** hold `rst` 2 cycles with `cells`=16'hA5C3. Cycles 0-1: `rows`=0, `cols`=0. Cycles 2-4: `rows`=4'b0001, `cols`=4'h3.
- **Row scan:** same pattern. Expected `rows`/`cols`:
  - cycles 7-9: 0010 / C
  - cycles 12-14: 0100 / 5
  - cycles 17-19: 1000 / A
  - cycle 22: back to 0001 / 3
- **Tear-free:** set `cells`=16'hFFFF at cycle 8 with no `ena`. Rows 1-3 still show C, 5, A, and row 0 still shows 3 at cycle 22. Pulse `ena` at cycle 10: row 0 shows F from cycle 22, and rows 1-3 show F from cycles 27, 32 and 37 respectively.
- **frame_done:** high only on cycles 19, 39 and 59 during free run; never two consecutive cycles.
- **Simultaneous / multiple ena:**
  - `ena` at cycle 20, so `ena_d`=1 exactly on the load cycle 21: the new pattern shows at cycle 22.
  - Two `ena` pulses in one frame: only the second generation is displayed.
- **Reset mid-frame:** assert `rst` at cycle 13. `rows`=0 from cycle 14. After release, the scan restarts at row 0 with a fresh snapshot of `cells`.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and helpers for the Game-of-Life cell array and its display scanner.
package conway_pkg;

  // Prefixed literals keep them distinct from the BLANK/DWELL timing parameters.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Flat bit index of cell (r,c) on an n-by-n board.
  function automatic int cell_index(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/row_decoder.sv
// Binary row index plus enable to a one-hot, active-high row drive vector.
module row_decoder #(
  parameter int N  = 8,
  parameter int RW = $clog2(N)
) (
  input  logic [RW-1:0] row_i,
  input  logic          en_i,
  output logic [N-1:0]  rows_o
);

  for (genvar i = 0; i < N; i++) begin : g_row
    assign rows_o[i] = en_i && (row_i == RW'(i));
  end

endmodule

// File: rtl/life_display_scanner.sv
// Holds a tear-free snapshot of the cell array and scans it onto an N x N LED
// matrix one row at a time, with a dark gap before every row.
module life_display_scanner
  import conway_pkg::*;
#(
  parameter int N     = 8,
  parameter int DWELL = 1024,
  parameter int BLANK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [N*N-1:0] cells,
  output logic [N-1:0]   rows,
  output logic [N-1:0]   cols,
  output logic           frame_done
);

  localparam int RW   = $clog2(N);
  localparam int PMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int PW   = $clog2(PMAX + 1);

  scan_state_e    state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [N*N-1:0] snap_q, snap_d;
  logic           pending_q, pending_d;
  logic           ena_d_q;
  logic           load;
  logic           drive;

  // Only the last dark cycle of row 0 may refresh the snapshot, so a frame is
  // always painted from a single generation.
  assign load = (state_q == ST_BLANK) && (row_q == '0) &&
                (phase_q == PW'(BLANK - 1)) && (pending_q || ena_d_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    phase_d   = phase_q + 1'b1;
    snap_d    = snap_q;
    pending_d = pending_q;

    unique case (state_q)
      ST_BLANK: begin
        if (phase_q == PW'(BLANK - 1)) begin
          phase_d = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (phase_q == PW'(DWELL - 1)) begin
          phase_d = '0;
          state_d = ST_BLANK;
          row_d   = (row_q == RW'(N - 1)) ? '0 : row_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    if (load) begin
      snap_d    = cells;
      pending_d = 1'b0;
    end else if (ena_d_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      row_q     <= '0;
      phase_q   <= '0;
      snap_q    <= '0;
      pending_q <= 1'b1;
      ena_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      phase_q   <= phase_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      ena_d_q   <= ena;
    end
  end

  assign drive = (state_q == ST_DRIVE);

  row_decoder #(.N(N), .RW(RW)) u_row_decoder (
    .row_i  (row_q),
    .en_i   (drive),
    .rows_o (rows)
  );

  assign cols       = drive ? snap_q[cell_index(int'(row_q), 0, N) +: N] : '0;
  assign frame_done = drive && (row_q == RW'(N - 1)) && (phase_q == PW'(DWELL - 1));

endmodule

// File: tb/tb_life_display_scanner.sv
// Directed scan, tear-free, ena timing and mid-frame reset checks at N=4, DWELL=3, BLANK=2.
module tb_life_display_scanner;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [N*N-1:0] cells;
  logic [N-1:0]   rows;
  logic [N-1:0]   cols;
  logic           frame_done;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;

  life_display_scanner #(.N(N), .DWELL(3), .BLANK(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cells      (cells),
    .rows       (rows),
    .cols       (cols),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [3:0] er, input logic [3:0] ec, input logic ef);
    n_asrt++;
    assert (rows === er) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d rows=%b expected %b", tag, cyc, rows, er);
    end
    n_asrt++;
    assert (cols === ec) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d cols=%h expected %h", tag, cyc, cols, ec);
    end
    n_asrt++;
    assert (frame_done === ef) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d frame_done=%b expected %b", tag, cyc, frame_done, ef);
    end
  endtask

  initial begin
    rst   = 1'b1;
    ena   = 1'b0;
    cells = 16'hA5C3;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;

    // Reset and first row
    chk("reset_c0", 4'b0000, 4'h0, 1'b0);
    goto(1);  chk("reset_c1", 4'b0000, 4'h0, 1'b0);
    goto(2);  chk("row0_c2",  4'b0001, 4'h3, 1'b0);
    goto(4);  chk("row0_c4",  4'b0001, 4'h3, 1'b0);
    goto(5);  chk("blank_c5", 4'b0000, 4'h0, 1'b0);
    goto(7);  chk("row1_c7",  4'b0010, 4'hC, 1'b0);

    // Cells change without ena: display must not tear
    goto(8);  chk("row1_c8",  4'b0010, 4'hC, 1'b0);
    cells = 16'hFFFF;
    goto(9);  chk("row1_c9",  4'b0010, 4'hC, 1'b0);
    goto(10); ena = 1'b1;
    goto(11); ena = 1'b0;
    goto(12); chk("row2_c12", 4'b0100, 4'h5, 1'b0);
    goto(14); chk("row2_c14", 4'b0100, 4'h5, 1'b0);
    goto(17); chk("row3_c17", 4'b1000, 4'hA, 1'b0);
    goto(18); chk("fd_c18",   4'b1000, 4'hA, 1'b0);
    goto(19); chk("fd_c19",   4'b1000, 4'hA, 1'b1);
    goto(20); chk("fd_c20",   4'b0000, 4'h0, 1'b0);
    goto(22); chk("newgen_r0", 4'b0001, 4'hF, 1'b0);
    goto(27); chk("newgen_r1", 4'b0010, 4'hF, 1'b0);
    goto(32); chk("newgen_r2", 4'b0100, 4'hF, 1'b0);
    goto(37); chk("newgen_r3", 4'b1000, 4'hF, 1'b0);
    goto(39); chk("fd_c39",   4'b1000, 4'hF, 1'b1);
    goto(40); chk("fd_c40",   4'b0000, 4'h0, 1'b0);
    goto(59); chk("fd_c59",   4'b1000, 4'hF, 1'b1);

    // ena_d coincides with the load cycle
    goto(60); cells = 16'h1234; ena = 1'b1;
    goto(61); ena = 1'b0;
    goto(62); chk("simul_r0", 4'b0001, 4'h4, 1'b0);
    goto(67); chk("simul_r1", 4'b0010, 4'h3, 1'b0);
    goto(70); cells = 16'hEEEE;
    goto(82); chk("nopend_r0", 4'b0001, 4'h4, 1'b0);

    // Two generations in one frame: only the later one shows
    goto(85); cells = 16'h5678; ena = 1'b1;
    goto(86); ena = 1'b0;
    goto(90); cells = 16'h9ABC; ena = 1'b1;
    goto(91); ena = 1'b0;
    goto(92); chk("multi_old_r2", 4'b0100, 4'h2, 1'b0);
    goto(102); chk("multi_r0", 4'b0001, 4'hC, 1'b0);
    goto(107); chk("multi_r1", 4'b0010, 4'hB, 1'b0);

    // Reset mid-frame with a generation pending
    goto(110); cells = 16'h4321; ena = 1'b1;
    goto(111); ena = 1'b0;
    goto(112); chk("prerst_r2", 4'b0100, 4'hA, 1'b0);
    goto(113); rst = 1'b1; cells = 16'h0F0F;
    goto(114); rst = 1'b0;
    chk("midrst_dark", 4'b0000, 4'h0, 1'b0);
    goto(115); chk("midrst_c1", 4'b0000, 4'h0, 1'b0);
    goto(116); chk("midrst_r0", 4'b0001, 4'hF, 1'b0);
    goto(121); chk("midrst_r1", 4'b0010, 4'h0, 1'b0);
    goto(133); chk("midrst_fd", 4'b1000, 4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
